ahb_arbiter: RTL

Fixed-priority AHB bus arbiter for up to 16 masters. It consumes each master's `hbusreq`/`hlock` request pair and produces the one-hot `hgrant` vector, the `hmaster` owner index and `hmastlock`. These outputs are checked by the per-master request interface assertions. Arbitration advances only on cycles where `hready` is high. Locked sequences hold the bus, plus one extra grant cycle after `hlock` drops. With no requests, the bus parks on the lowest-priority master.

---
 rtl/ahb_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/ahb_arbiter.sv
// Fixed-priority AHB arbiter: index 0 wins, the highest index is the park master.
// Locked transfers hold the bus until hlock drops, plus one tail grant cycle.
module ahb_arbiter #(
    parameter int NUM_MASTERS = 4
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [3:0]             hmaster,
    output logic                   hmastlock
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {
        ARB,
        LOCKED,
        LOCK_TAIL
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [3:0]             hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;

    logic [IDX_W-1:0]       grantIdx;
    logic [IDX_W-1:0]       winnerIdx;
    logic [NUM_MASTERS-1:0] winnerOneHot;

    // An all-zero grant (only right after reset) reads as the park master.
    always_comb begin
        grantIdx = IDX_W'(NUM_MASTERS - 1);
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant_q[i]) begin
                grantIdx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        winnerIdx = IDX_W'(NUM_MASTERS - 1);
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (hbusreq[i] || hlock[i]) begin
                winnerIdx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        winnerOneHot = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            winnerOneHot[i] = (winnerIdx == IDX_W'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        hgrant_d    = hgrant_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (hready) begin
            hmaster_d   = 4'(grantIdx);
            hmastlock_d = hlock[grantIdx];
            case (state_q)
                LOCKED: begin
                    if (!hlock[grantIdx]) begin
                        state_d = LOCK_TAIL;
                    end
                end
                // The tail cycle re-arbitrates just like ARB, so both share this path.
                default: begin
                    hgrant_d = winnerOneHot;
                    state_d  = (hlock[winnerIdx] && hbusreq[winnerIdx]) ? LOCKED : ARB;
                end
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset) begin
            state_q     <= ARB;
            hgrant_q    <= '0;
            hmaster_q   <= 4'(NUM_MASTERS - 1);
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule
